// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and the shared memory port.
// slave = arbiter view, master = environment view (pipeline + memory model).
interface mem_port_arbiter_if;
  logic [63:0] imem_addr;
  logic        imem_addr_valid;
  logic [63:0] imem_data;
  logic        imem_data_valid;

  logic [63:0] dmem_addr;
  logic        dmem_addr_valid;
  logic        dmem_we;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_data;
  logic        dmem_data_valid;

  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  // Handshake: *_addr_valid is held until the one-cycle *_data_valid strobe;
  // mem_req is held with stable mem_addr/we/wdata until mem_ack, rdata valid with ack.
  modport slave (
    input  imem_addr, imem_addr_valid,
    output imem_data, imem_data_valid,
    input  dmem_addr, dmem_addr_valid, dmem_we, dmem_wdata,
    output dmem_data, dmem_data_valid,
    output mem_req, mem_addr, mem_we, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output imem_addr, imem_addr_valid,
    input  imem_data, imem_data_valid,
    output dmem_addr, dmem_addr_valid, dmem_we, dmem_wdata,
    input  dmem_data, dmem_data_valid,
    input  mem_req, mem_addr, mem_we, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters; data has priority,
// fetch starvation bounded by STARVE_LIMIT. Optional counters: define MEMARB_STATS_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0]         stat_fetch_wait,
  output logic [31:0]         stat_data_grants
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        grant_i, grant_d;

  logic        mem_req_q, mem_req_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [63:0] imem_data_q, imem_data_d;
  logic        imem_dv_q, imem_dv_d;
  logic [63:0] dmem_data_q, dmem_data_d;
  logic        dmem_dv_q, dmem_dv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      imem_data_q <= '0;
      imem_dv_q   <= 1'b0;
      dmem_data_q <= '0;
      dmem_dv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      imem_data_q <= imem_data_d;
      imem_dv_q   <= imem_dv_d;
      dmem_data_q <= dmem_data_d;
      dmem_dv_q   <= dmem_dv_d;
    end
  end

  // Data wins unless a waiting fetch has already been passed over LIMIT times.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.dmem_addr_valid && (streak_q < LIMIT)) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
        end else if (bus.imem_addr_valid) begin
          grant_i = 1'b1;
          state_d = I_BUSY;
        end else if (bus.dmem_addr_valid) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.mem_ack) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    imem_data_d = imem_data_q;
    imem_dv_d   = 1'b0;
    dmem_data_d = dmem_data_q;
    dmem_dv_d   = 1'b0;

    if (grant_d) begin
      mem_req_d   = 1'b1;
      mem_addr_d  = bus.dmem_addr;
      mem_we_d    = bus.dmem_we;
      mem_wdata_d = bus.dmem_wdata;
      streak_d    = bus.imem_addr_valid ? (streak_q + 4'd1) : 4'd0;
    end
    if (grant_i) begin
      mem_req_d   = 1'b1;
      mem_addr_d  = bus.imem_addr;
      mem_we_d    = 1'b0;
      mem_wdata_d = '0;
      streak_d    = 4'd0;
    end
    if ((state_q == I_BUSY) && bus.mem_ack) begin
      imem_data_d = bus.mem_rdata;
      imem_dv_d   = 1'b1;
      mem_req_d   = 1'b0;
    end
    if ((state_q == D_BUSY) && bus.mem_ack) begin
      dmem_data_d = bus.mem_rdata;
      dmem_dv_d   = 1'b1;
      mem_req_d   = 1'b0;
    end
  end

  assign bus.mem_req         = mem_req_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_we          = mem_we_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.imem_data       = imem_data_q;
  assign bus.imem_data_valid = imem_dv_q;
  assign bus.dmem_data       = dmem_data_q;
  assign bus.dmem_data_valid = dmem_dv_q;
  assign dbg_state           = state_q;

`ifdef MEMARB_STATS_EN
  logic [31:0] fetch_wait_q, fetch_wait_d;
  logic [31:0] data_grants_q, data_grants_d;
  logic        fetch_served;

  // A fetch is being served while in I_BUSY or in the RESP cycle of a fetch.
  always_comb begin
    fetch_served  = (state_q == I_BUSY) || ((state_q == RESP) && imem_dv_q);
    fetch_wait_d  = fetch_wait_q;
    data_grants_d = data_grants_q;
    if (bus.imem_addr_valid && !fetch_served && (fetch_wait_q != 32'hFFFF_FFFF))
      fetch_wait_d = fetch_wait_q + 32'd1;
    if (grant_d && (data_grants_q != 32'hFFFF_FFFF))
      data_grants_d = data_grants_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_wait_q  <= '0;
      data_grants_q <= '0;
    end else begin
      fetch_wait_q  <= fetch_wait_d;
      data_grants_q <= data_grants_d;
    end
  end

  assign stat_fetch_wait  = fetch_wait_q;
  assign stat_data_grants = data_grants_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder checks grants against an expected
// grant queue; a monitor checks every response strobe against an expected response queue.
module tb_mem_port_arbiter;
  typedef logic [191:0] val_t;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
`ifdef MEMARB_STATS_EN
  logic [31:0] stat_fetch_wait;
  logic [31:0] stat_data_grants;
`endif

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef MEMARB_STATS_EN
    ,
    .stat_fetch_wait  (stat_fetch_wait),
    .stat_data_grants (stat_data_grants)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // {we, addr, wdata} per grant; {is_data, data} per response
  logic [128:0] exp_grant_q[$];
  logic [64:0]  exp_q[$];

  int   ack_delay    = 0;
  logic spurious_ack = 1'b0;

  task automatic check(input string name, input val_t act, input val_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory responder: acks ack_delay cycles after mem_req rises; rdata = addr ^ FFFF<<48
  initial begin
    logic [128:0] held;
    logic [128:0] eg;
    logic         seen;
    int           cnt;
    seen = 1'b0;
    cnt  = 0;
    held = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_ack = 1'b0;
      if (!rst_n) begin
        seen = 1'b0;
        cnt  = 0;
      end else if (bus.mem_req) begin
        if (!seen) begin
          seen = 1'b1;
          cnt  = 0;
          held = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
          if (exp_grant_q.size() == 0) begin
            check("unexpected_grant", val_t'(held), val_t'(0));
          end else begin
            eg = exp_grant_q.pop_front();
            check("grant_we_addr_wdata", val_t'(held), val_t'(eg));
          end
        end else begin
          check("mem_hold_stable", val_t'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), val_t'(held));
        end
        if (cnt == ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_addr ^ 64'hFFFF_0000_0000_0000;
          seen = 1'b0;
        end else begin
          cnt++;
        end
      end else begin
        seen = 1'b0;
        if (spurious_ack) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
          spurious_ack  = 1'b0;
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic        prev_ack;
    logic [64:0] e;
    logic [64:0] got;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.imem_data_valid || bus.dmem_data_valid)) begin
        if (bus.imem_data_valid && bus.dmem_data_valid)
          check("both_valid", val_t'(1), val_t'(0));
        check("resp_after_ack", val_t'(prev_ack), val_t'(1));
        got = bus.dmem_data_valid ? {1'b1, bus.dmem_data} : {1'b0, bus.imem_data};
        if (exp_q.size() == 0) begin
          check("unexpected_resp", val_t'(got), val_t'(0));
        end else begin
          e = exp_q.pop_front();
          check("resp_port_data", val_t'(got), val_t'(e));
        end
      end
      prev_ack = bus.mem_ack;
    end
  end

  // driver tasks: called at posedge+1; return cycles until the response strobe
  task automatic do_fetch(input logic [63:0] addr, output int lat);
    lat = -1;
    bus.imem_addr       = addr;
    bus.imem_addr_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.imem_data_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("fetch_timeout", val_t'(0), val_t'(1));
    @(posedge clk);
    #1;
    bus.imem_addr_valid = 1'b0;
  endtask

  task automatic do_data(input logic [63:0] addr, input logic we, input logic [63:0] wdata,
                         output int lat);
    lat = -1;
    bus.dmem_addr       = addr;
    bus.dmem_we         = we;
    bus.dmem_wdata      = wdata;
    bus.dmem_addr_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.dmem_data_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("data_timeout", val_t'(0), val_t'(1));
    @(posedge clk);
    #1;
    bus.dmem_addr_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_req"},   val_t'(bus.mem_req),         val_t'(0));
    check({tag, "_mem_addr"},  val_t'(bus.mem_addr),        val_t'(0));
    check({tag, "_mem_we"},    val_t'(bus.mem_we),          val_t'(0));
    check({tag, "_mem_wdata"}, val_t'(bus.mem_wdata),       val_t'(0));
    check({tag, "_imem_data"}, val_t'(bus.imem_data),       val_t'(0));
    check({tag, "_imem_dv"},   val_t'(bus.imem_data_valid), val_t'(0));
    check({tag, "_dmem_data"}, val_t'(bus.dmem_data),       val_t'(0));
    check({tag, "_dmem_dv"},   val_t'(bus.dmem_data_valid), val_t'(0));
    check({tag, "_state"},     val_t'(dbg_state),           val_t'(0));
  endtask

  // concurrent-run vectors: data i at 2000+8i, i==2 is a write; fetches at 1000, 1004
  logic [63:0] d_addr  [8] = '{64'h2000, 64'h2008, 64'h2010, 64'h2018,
                               64'h2020, 64'h2028, 64'h2030, 64'h2038};
  logic        d_we    [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [63:0] d_wdata [8] = '{64'h0, 64'h0, 64'h1234, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
  logic [63:0] i_addr  [2] = '{64'h1000, 64'h1004};

  initial begin
    int  lat;
    bit  found;
    int  di;
    int  ii;
    rst_n = 1'b0;
    bus.imem_addr       = '0;
    bus.imem_addr_valid = 1'b0;
    bus.dmem_addr       = '0;
    bus.dmem_addr_valid = 1'b0;
    bus.dmem_we         = 1'b0;
    bus.dmem_wdata      = '0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single fetch, ack immediately
    exp_grant_q.push_back({1'b0, 64'h100, 64'h0});
    exp_q.push_back({1'b0, 64'hFFFF_0000_0000_0100});
    do_fetch(64'h100, lat);
    check("fetch_latency", val_t'(lat), val_t'(2));

    // data write
    exp_grant_q.push_back({1'b1, 64'h2000, 64'hDEAD_BEEF});
    exp_q.push_back({1'b1, 64'hFFFF_0000_0000_2000});
    do_data(64'h2000, 1'b1, 64'hDEAD_BEEF, lat);
    check("write_latency", val_t'(lat), val_t'(2));

    // data read
    exp_grant_q.push_back({1'b0, 64'h3008, 64'h0});
    exp_q.push_back({1'b1, 64'hFFFF_0000_0000_3008});
    do_data(64'h3008, 1'b0, 64'h0, lat);
    check("read_latency", val_t'(lat), val_t'(2));
    check("imem_data_held", val_t'(bus.imem_data), val_t'(64'hFFFF_0000_0000_0100));

    // both requesting continuously: D,D,D,D,I,D,D,D,D,I
    di = 0;
    ii = 0;
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) begin
        exp_grant_q.push_back({1'b0, i_addr[ii], 64'h0});
        exp_q.push_back({1'b0, i_addr[ii] ^ 64'hFFFF_0000_0000_0000});
        ii++;
      end else begin
        exp_grant_q.push_back({d_we[di], d_addr[di], d_wdata[di]});
        exp_q.push_back({1'b1, d_addr[di] ^ 64'hFFFF_0000_0000_0000});
        di++;
      end
    end
    fork
      begin
        int l;
        for (int i = 0; i < 8; i++) do_data(d_addr[i], d_we[i], d_wdata[i], l);
      end
      begin
        int l;
        for (int j = 0; j < 2; j++) do_fetch(i_addr[j], l);
      end
    join
    check("starve_run_grants_left", val_t'(exp_grant_q.size()), val_t'(0));

    // slow memory, then a spurious ack while idle
    ack_delay = 5;
    exp_grant_q.push_back({1'b0, 64'h400, 64'h0});
    exp_q.push_back({1'b0, 64'hFFFF_0000_0000_0400});
    do_fetch(64'h400, lat);
    check("slow_fetch_latency", val_t'(lat), val_t'(7));
    spurious_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_spurious", val_t'(dbg_state), val_t'(0));
    check("imem_data_after_spurious", val_t'(bus.imem_data), val_t'(64'hFFFF_0000_0000_0400));

    // reset in the middle of a data access, fetch pending
    exp_grant_q.push_back({1'b0, 64'h5000, 64'h0});
    bus.dmem_addr       = 64'h5000;
    bus.dmem_we         = 1'b0;
    bus.dmem_wdata      = 64'h0;
    bus.dmem_addr_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        found = 1'b1;
        break;
      end
    end
    check("reset_test_req_seen", val_t'(found), val_t'(1));
    @(posedge clk);
    #1;
    bus.imem_addr       = 64'h600;
    bus.imem_addr_valid = 1'b1;
    check("state_d_busy", val_t'(dbg_state), val_t'(2));
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    bus.dmem_addr_valid = 1'b0;
    ack_delay = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_grant_q.push_back({1'b0, 64'h600, 64'h0});
    exp_q.push_back({1'b0, 64'hFFFF_0000_0000_0600});
    do_fetch(64'h600, lat);
    check("post_reset_fetch_latency", val_t'(lat), val_t'(2));

    repeat (3) @(posedge clk);
    check("grants_left", val_t'(exp_grant_q.size()), val_t'(0));
    check("resps_left", val_t'(exp_q.size()), val_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
